// File: rtl/mpkt_pkg.sv
// Shared definitions for the mesh packet input-buffer controller:
// packet-type encodings, coordinate widths, FSM state encoding and the
// helper that picks the first copy target of a multicast/broadcast.
package mpkt_pkg;

    localparam int unsigned COORD_W = 3;
    localparam int unsigned TGT_W   = 2 * COORD_W;

    typedef enum logic [1:0] {
        PKT_UNI   = 2'b00,
        PKT_COL   = 2'b01,
        PKT_ROW   = 2'b10,
        PKT_BCAST = 2'b11
    } pkt_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        COPY = 2'd2
    } state_e;

    // Target is {y, x}; column sweeps y from 0, row sweeps x from 0,
    // broadcast sweeps every node starting at the origin.
    function automatic logic [TGT_W-1:0] first_tgt(input pkt_type_e typ,
                                                   input logic [TGT_W-1:0] tgt);
        logic [TGT_W-1:0] res;
        res = tgt;
        case (typ)
            PKT_COL:   res = {{COORD_W{1'b0}}, tgt[COORD_W-1:0]};
            PKT_ROW:   res = {tgt[TGT_W-1:COORD_W], {COORD_W{1'b0}}};
            PKT_BCAST: res = '0;
            default:   res = tgt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mpkt_tgt_step.sv
// Next copy target and final-copy detection for the expansion sweep.
// Pure combinational; coordinates wrap within their 3-bit fields.
module mpkt_tgt_step
    import mpkt_pkg::*;
(
    input  logic [TGT_W-1:0] cur_tgt,
    input  pkt_type_e        typ,
    output logic [TGT_W-1:0] nxt_tgt,
    output logic             is_final
);

    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;

    assign cur_x = cur_tgt[COORD_W-1:0];
    assign cur_y = cur_tgt[TGT_W-1:COORD_W];

    // Step along the sweep for the packet type and flag the last node
    always_comb begin
        nxt_tgt  = cur_tgt;
        is_final = 1'b1;
        case (typ)
            PKT_COL: begin
                nxt_tgt  = {cur_y + COORD_W'(1), cur_x};
                is_final = (cur_y == '1);
            end
            PKT_ROW: begin
                nxt_tgt  = {cur_y, cur_x + COORD_W'(1)};
                is_final = (cur_x == '1);
            end
            PKT_BCAST: begin
                nxt_tgt  = {(cur_x == '1) ? cur_y + COORD_W'(1) : cur_y,
                            cur_x + COORD_W'(1)};
                is_final = (cur_tgt == '1);
            end
            default: begin
                nxt_tgt  = cur_tgt;
                is_final = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mpkt_ibuf_ctrl.sv
// Input-buffer controller: accepts one packet at a time from port A and
// either forwards it unchanged (HOLD) or expands a multicast/broadcast into
// unicast copies (COPY), steering around a faulty node. Unicasts addressed
// to the faulty node are dropped.
// Optional feature: define MPKT_SKIP_CNT_EN to add the saturating skip_cnt
// output counting dropped unicasts and skipped copies.
module mpkt_ibuf_ctrl
    import mpkt_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [1:0]    in_type,
    input  logic [5:0]    in_tgt,
    input  logic [DW-1:0] in_data,
    input  logic          pg_en,
    input  logic [5:0]    pg_node,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [1:0]    out_type,
    output logic [5:0]    out_tgt,
    output logic [DW-1:0] out_data,
    output logic          busy
`ifdef MPKT_SKIP_CNT_EN
    ,
    output logic [15:0]   skip_cnt
`endif
);

    state_e            state_q, state_d;
    pkt_type_e         typ_q, typ_d;
    logic [TGT_W-1:0]  pg_node_q, pg_node_d;
    logic              out_vld_d;
    logic [1:0]        out_type_d;
    logic [TGT_W-1:0]  out_tgt_d;
    logic [DW-1:0]     out_data_d;

    pkt_type_e         in_pkt;
    logic              out_hs;
    logic              copy_step;
    logic              last_go;
    logic              accept;
    logic              is_drop;
    logic              is_copy;
    logic [TGT_W-1:0]  start_tgt;
    logic [TGT_W-1:0]  step_nxt;
    logic              step_final;

    mpkt_tgt_step u_tgt_step (
        .cur_tgt  (out_tgt),
        .typ      (typ_q),
        .nxt_tgt  (step_nxt),
        .is_final (step_final)
    );

    // Handshake decode; a copy slot is consumed by a handshake or by a skip
    // (out_vld low in COPY), which is what lets in_rdy rise on a skipped final
    always_comb begin
        in_pkt    = pkt_type_e'(in_type);
        out_hs    = out_vld & out_rdy;
        copy_step = (state_q == COPY) & (out_hs | ~out_vld);
        last_go   = ((state_q == HOLD) & out_hs) | (copy_step & step_final);
        in_rdy    = (state_q == IDLE) | last_go;
        accept    = in_vld & in_rdy;
        is_drop   = pg_en & (in_pkt == PKT_UNI) & (in_tgt == pg_node);
        is_copy   = pg_en & (in_pkt != PKT_UNI);
        start_tgt = first_tgt(in_pkt, in_tgt);
        busy      = (state_q != IDLE);
    end

    // Next-state and next-beat computation; an acceptance overrides the
    // retirement of the current packet so back-to-back packets see no bubble
    always_comb begin
        state_d    = state_q;
        typ_d      = typ_q;
        pg_node_d  = pg_node_q;
        out_vld_d  = out_vld;
        out_type_d = out_type;
        out_tgt_d  = out_tgt;
        out_data_d = out_data;
        case (state_q)
            IDLE: ;
            HOLD: begin
                if (out_hs) begin
                    state_d   = IDLE;
                    out_vld_d = 1'b0;
                end
            end
            COPY: begin
                if (copy_step) begin
                    if (step_final) begin
                        state_d   = IDLE;
                        out_vld_d = 1'b0;
                    end else begin
                        out_tgt_d = step_nxt;
                        out_vld_d = (step_nxt != pg_node_q);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                out_vld_d = 1'b0;
            end
        endcase
        if (accept) begin
            typ_d     = in_pkt;
            pg_node_d = pg_node;
            if (is_drop) begin
                state_d   = IDLE;
                out_vld_d = 1'b0;
            end else if (is_copy) begin
                state_d    = COPY;
                out_type_d = PKT_UNI;
                out_tgt_d  = start_tgt;
                out_data_d = in_data;
                out_vld_d  = (start_tgt != pg_node);
            end else begin
                state_d    = HOLD;
                out_type_d = in_type;
                out_tgt_d  = in_tgt;
                out_data_d = in_data;
                out_vld_d  = 1'b1;
            end
        end
    end

    // State, presented beat and per-packet latched context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            typ_q     <= PKT_UNI;
            pg_node_q <= '0;
            out_vld   <= 1'b0;
            out_type  <= '0;
            out_tgt   <= '0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            typ_q     <= typ_d;
            pg_node_q <= pg_node_d;
            out_vld   <= out_vld_d;
            out_type  <= out_type_d;
            out_tgt   <= out_tgt_d;
            out_data  <= out_data_d;
        end
    end

`ifdef MPKT_SKIP_CNT_EN
    logic        drop_evt;
    logic        skip_evt;
    logic [16:0] skip_sum;

    // A dropped unicast and a skipped final copy can coincide, so up to two
    // events are added per cycle before saturating
    always_comb begin
        drop_evt = accept & is_drop;
        skip_evt = (state_q == COPY) & ~out_vld;
        skip_sum = {1'b0, skip_cnt} + {16'd0, drop_evt} + {16'd0, skip_evt};
    end

    // Saturating skip counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt <= '0;
        end else begin
            skip_cnt <= skip_sum[16] ? 16'hFFFF : skip_sum[15:0];
        end
    end
`endif

endmodule

// File: doc/mpkt_ibuf_ctrl.md
MPKT_IBUF_CTRL -- requirements
Module: mpkt_ibuf_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, payload width in bits.
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports in_vld/in_rdy, input/output, 1 each, upstream port-A handshake.
REQ-005 SHALL have ports in_type, in_tgt, in_data, inputs, 2/6/DW: packet type (00 uni, 01 column-multi, 10 row-multi, 11 broadcast), target {y[2:0],x[2:0]}, payload.
REQ-006 SHALL have ports pg_en, input, 1 (faulty node present), and pg_node, input, 6 (faulty node coordinate).
REQ-007 SHALL have ports out_vld/out_rdy, output/input, 1 each, downstream handshake.
REQ-008 SHALL have ports out_type, out_tgt, out_data, outputs, 2/6/DW, all registered.
REQ-009 SHALL have port busy, output, 1, high while a packet is held or expanding.

Function
REQ-010 SHALL transfer on in_vld&in_rdy and on out_vld&out_rdy; out_* SHALL stay stable while out_vld&!out_rdy.
REQ-011 SHALL drive in_rdy = (state==IDLE) | (final copy handshaking this cycle), allowing back-to-back packets with zero bubble.
REQ-012 SHALL latch pg_en and pg_node at acceptance; later changes SHALL not affect the packet in flight.
REQ-013 SHALL, with latched pg_en=0 or type 00, present the packet unchanged one cycle after acceptance (state HOLD).
REQ-014 SHALL, with latched pg_en=1 and type 00 and in_tgt==pg_node, drop the packet (never assert out_vld) and remain IDLE.
REQ-015 SHALL, with latched pg_en=1 and type!=00, enter COPY and emit unicast copies (out_type=00, same out_data) in this order: 01 -> y=0..7 at fixed x; 10 -> x=0..7 at fixed y; 11 -> all 64 nodes, x fastest, from 0x00 to 0x3F.
REQ-016 SHALL skip any copy whose tgt==latched pg_node: out_vld low for that one cycle, then advance to the next tgt.
REQ-017 SHALL advance tgt only on a copy handshake or a skip; increments use 3-bit fields; for broadcast, y increments when x==7.
REQ-018 SHALL detect the final copy before wrap (01: y==7; 10: x==7; 11: tgt==6'h3F); after it is handshaked or skipped, SHALL go IDLE (or load the next packet if accepted that cycle).
REQ-019 State machine SHALL be IDLE -> HOLD|COPY on accept; HOLD -> IDLE|HOLD(new) on out handshake; COPY -> COPY on step, -> IDLE|HOLD|COPY on final.
REQ-020 busy SHALL equal (state!=IDLE).

Reset
REQ-021 On rst_n low, SHALL force state IDLE, out_vld=0, out_type=0, out_tgt=0, out_data=0, busy=0; in_rdy SHALL read 1 after release.
REQ-022 Reset asserted mid-COPY SHALL abandon the remaining copies with no further out_vld.

Configuration
REQ-023 With MPKT_SKIP_CNT_EN defined, SHALL provide output skip_cnt[15:0], incremented (saturating at 16'hFFFF) on every dropped unicast and every skipped copy, reset to 0.
REQ-024 Without MPKT_SKIP_CNT_EN, skip_cnt port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-025 SHALL take packet-type encodings (PKT_UNI/COL/ROW/BCAST), coordinate width 3, and the state enum from shared package mpkt_pkg.
REQ-026 SHALL place next-target and final-copy computation in one sub-module, mpkt_tgt_step (combinational; cur_tgt, type -> nxt_tgt, is_final).

Verification
REQ-027 pg_en=0, type 11, tgt 0x12, out_rdy=1 -> one beat next cycle, out_type=11, out_tgt=0x12.
REQ-028 pg_en=1, pg_node=0x1A, type 01, tgt x=2 -> 7 copies with y=0,1,2,4,5,6,7 at x=2, one-cycle gap at y=3, skip_cnt=1.
REQ-029 pg_en=1, pg_node=0x3F, type 11, out_rdy=1 -> 63 copies 0x00..0x3E, no beat for 0x3F, in_rdy high after 64 cycles.
REQ-030 pg_en=1, type 10, out_rdy toggled every other cycle -> out_tgt held stable while stalled; all 8 copies delivered in order.
REQ-031 pg_en=1, unicast tgt==pg_node -> no out_vld, in_rdy stays 1, skip_cnt increments.
REQ-032 rst_n pulsed low during broadcast copy 10 -> out_vld=0 immediately, IDLE after release, no residual copies.
